// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversampled bit timing, 3-sample majority voting,
// runtime data length / parity / stop-bit selection, registered status pulses.
module uart_rx_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESC_W    = 6
) (
   input  logic                  FSM_CLK,
   input  logic                  FSM_RST,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  STOP2,
   input  logic [3:0]            DATA_LEN,
   input  logic [PRESC_W-1:0]    Prescale,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err,
   output logic                  busy
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   localparam logic [3:0]         MIN_LEN = 4'd5;
   localparam logic [3:0]         MAX_LEN = 4'(DATA_WIDTH);
   localparam logic [PRESC_W-1:0] ONE     = PRESC_W'(1);

   state_t                state, state_nxt;
   logic [PRESC_W-1:0]    edge_cnt, edge_nxt;
   logic [PRESC_W-1:0]    presc_q, presc_nxt;
   logic [3:0]            bit_cnt, bit_nxt;
   logic [3:0]            len_q, len_nxt;
   logic                  par_en_q, par_en_nxt;
   logic                  par_typ_q, par_typ_nxt;
   logic                  stop2_q, stop2_nxt;
   logic                  stop_idx, stop_idx_nxt;
   logic                  par_flag, par_flag_nxt;
   logic                  stp_flag, stp_flag_nxt;
   logic [2:0]            samp, samp_nxt;
   logic [DATA_WIDTH-1:0] shift_q, shift_nxt;
   logic [DATA_WIDTH-1:0] p_data_nxt;
   logic                  dv_nxt, pe_nxt, se_nxt, busy_nxt;

   logic [3:0]            len_in;
   logic [PRESC_W-1:0]    half;
   logic                  bit_end;
   logic                  third;
   logic                  maj;

   assign len_in  = (DATA_LEN < MIN_LEN || DATA_LEN > MAX_LEN) ? MAX_LEN : DATA_LEN;
   assign half    = presc_q >> 1;
   assign bit_end = (edge_cnt == presc_q - ONE);

   // With Prescale=4 the third sample falls on the bit-end clock, so vote on the live input.
   assign third = (edge_cnt == half + ONE) ? RX_IN : samp[2];
   assign maj   = (samp[0] & samp[1]) | (samp[0] & third) | (samp[1] & third);

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt    = state;
      edge_nxt     = edge_cnt;
      presc_nxt    = presc_q;
      bit_nxt      = bit_cnt;
      len_nxt      = len_q;
      par_en_nxt   = par_en_q;
      par_typ_nxt  = par_typ_q;
      stop2_nxt    = stop2_q;
      stop_idx_nxt = stop_idx;
      par_flag_nxt = par_flag;
      stp_flag_nxt = stp_flag;
      samp_nxt     = samp;
      shift_nxt    = shift_q;
      p_data_nxt   = P_DATA;
      dv_nxt       = 1'b0;
      pe_nxt       = 1'b0;
      se_nxt       = 1'b0;

      if (state != IDLE) begin
         edge_nxt = bit_end ? '0 : edge_cnt + ONE;
         if (edge_cnt == half - ONE) samp_nxt[0] = RX_IN;
         if (edge_cnt == half)       samp_nxt[1] = RX_IN;
         if (edge_cnt == half + ONE) samp_nxt[2] = RX_IN;
      end

      case (state)
         IDLE: begin
            if (!RX_IN) begin
               state_nxt    = START;
               edge_nxt     = '0;
               bit_nxt      = '0;
               shift_nxt    = '0;
               stop_idx_nxt = 1'b0;
               par_flag_nxt = 1'b0;
               stp_flag_nxt = 1'b0;
               presc_nxt    = Prescale;
               len_nxt      = len_in;
               par_en_nxt   = PAR_EN;
               par_typ_nxt  = PAR_TYP;
               stop2_nxt    = STOP2;
            end
         end
         START: begin
            if (bit_end) state_nxt = maj ? IDLE : DATA;
         end
         DATA: begin
            if (bit_end) begin
               shift_nxt = shift_q | (DATA_WIDTH'(maj) << bit_cnt);
               if (bit_cnt == len_q - 4'd1) state_nxt = par_en_q ? PARITY : STOP;
               else                         bit_nxt   = bit_cnt + 4'd1;
            end
         end
         PARITY: begin
            if (bit_end) begin
               if (maj != (^shift_q ^ par_typ_q)) par_flag_nxt = 1'b1;
               state_nxt = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               stp_flag_nxt = stp_flag | ~maj;
               if (stop2_q && !stop_idx) begin
                  stop_idx_nxt = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  if (par_flag || stp_flag_nxt) begin
                     pe_nxt = par_flag;
                     se_nxt = stp_flag_nxt;
                  end else begin
                     dv_nxt     = 1'b1;
                     p_data_nxt = shift_q;
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   // NOTE: state registers use non-blocking assignments so each one samples pre-edge values regardless of statement order.
   always_ff @(posedge FSM_CLK or negedge FSM_RST) begin
      if (!FSM_RST) begin
         state      <= IDLE;
         edge_cnt   <= '0;
         presc_q    <= '0;
         bit_cnt    <= '0;
         len_q      <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         stop2_q    <= 1'b0;
         stop_idx   <= 1'b0;
         par_flag   <= 1'b0;
         stp_flag   <= 1'b0;
         samp       <= '0;
         shift_q    <= '0;
         P_DATA     <= '0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         edge_cnt   <= edge_nxt;
         presc_q    <= presc_nxt;
         bit_cnt    <= bit_nxt;
         len_q      <= len_nxt;
         par_en_q   <= par_en_nxt;
         par_typ_q  <= par_typ_nxt;
         stop2_q    <= stop2_nxt;
         stop_idx   <= stop_idx_nxt;
         par_flag   <= par_flag_nxt;
         stp_flag   <= stp_flag_nxt;
         samp       <= samp_nxt;
         shift_q    <= shift_nxt;
         P_DATA     <= p_data_nxt;
         data_valid <= dv_nxt;
         par_err    <= pe_nxt;
         stp_err    <= se_nxt;
         busy       <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus random frames, checked against
// a frame-level model (expected word, error flags and pulse cycle per frame).
module tb_uart_rx_ctrl;

   localparam int DW = 8;
   localparam int PW = 6;

   logic          FSM_CLK = 1'b0;
   logic          FSM_RST;
   logic          RX_IN;
   logic          PAR_EN;
   logic          PAR_TYP;
   logic          STOP2;
   logic [3:0]    DATA_LEN;
   logic [PW-1:0] Prescale;
   logic [DW-1:0] P_DATA;
   logic          data_valid;
   logic          par_err;
   logic          stp_err;
   logic          busy;

   typedef struct {
      longint        cyc;
      bit            dv;
      bit            pe;
      bit            se;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          exp_q[$];
   longint        cyc = 0;
   longint        prev_end = 0;
   longint        last_pulse_cyc = -1;
   logic [DW-1:0] last_good = '0;
   int            n_checks = 0;
   int            n_errors = 0;
   bit            mon_en = 1'b0;

   uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
      .FSM_CLK    (FSM_CLK),
      .FSM_RST    (FSM_RST),
      .RX_IN      (RX_IN),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .STOP2      (STOP2),
      .DATA_LEN   (DATA_LEN),
      .Prescale   (Prescale),
      .P_DATA     (P_DATA),
      .data_valid (data_valid),
      .par_err    (par_err),
      .stp_err    (stp_err),
      .busy       (busy)
   );

   always #5 FSM_CLK = ~FSM_CLK;

   // Rising edges are numbered from 1; at a falling edge cyc names the edge just taken.
   always @(posedge FSM_CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Every pulse, and every expected pulse whose cycle has arrived, is matched in order.
   always @(negedge FSM_CLK) begin : monitor
      exp_t e;
      if (mon_en) begin
         if (data_valid || par_err || stp_err || (exp_q.size() != 0 && cyc >= exp_q[0].cyc)) begin
            if (exp_q.size() == 0) begin
               check("unexpected_pulse", {data_valid, par_err, stp_err}, 3'b000);
            end else begin
               e = exp_q.pop_front();
               check("pulse_cycle", cyc, e.cyc);
               check("data_valid", data_valid, e.dv);
               check("par_err", par_err, e.pe);
               check("stp_err", stp_err, e.se);
               if (e.dv) begin
                  check("p_data", P_DATA, e.data);
                  last_good = e.data;
               end else begin
                  check("p_data_held", P_DATA, last_good);
               end
               last_pulse_cyc = cyc;
            end
         end
      end
   end

   // Drives one frame from a falling clock edge and queues its expected outcome.
   // abort_bits > 0 drives only that many bit periods and queues nothing.
   task automatic send_frame(input logic [7:0] value, input logic [3:0] dlen, input bit pen,
                             input bit ptyp, input bit st2, input int presc, input bit par_flip,
                             input bit [1:0] stop_low, input int gap_bits, input int abort_bits,
                             output longint k0);
      int            eff_len;
      int            n_bits;
      logic [DW-1:0] word;
      bit            bits[$];
      longint        drive_edge;
      exp_t          e;
      eff_len = (dlen < 5 || dlen > DW) ? DW : int'(dlen);
      word    = value & DW'((1 << eff_len) - 1);
      bits.push_back(1'b0);
      for (int i = 0; i < eff_len; i++) bits.push_back(word[i]);
      if (pen) bits.push_back((^word) ^ ptyp ^ par_flip);
      bits.push_back(!stop_low[0]);
      if (st2) bits.push_back(!stop_low[1]);
      n_bits = bits.size();
      // The receiver only sees the start bit once it is back in IDLE.
      drive_edge = cyc + 1;
      k0         = (prev_end >= drive_edge) ? prev_end + 1 : drive_edge;
      prev_end   = k0 + longint'(n_bits) * presc;
      if (abort_bits == 0) begin
         e.cyc  = prev_end;
         e.pe   = pen && par_flip;
         e.se   = stop_low[0] || (st2 && stop_low[1]);
         e.dv   = !e.pe && !e.se;
         e.data = word;
         exp_q.push_back(e);
      end
      PAR_EN   = pen;
      PAR_TYP  = ptyp;
      STOP2    = st2;
      DATA_LEN = dlen;
      Prescale = PW'(presc);
      for (int i = 0; i < n_bits && (abort_bits == 0 || i < abort_bits); i++) begin
         RX_IN = bits[i];
         repeat (presc) @(negedge FSM_CLK);
      end
      RX_IN = 1'b1;
      repeat (gap_bits * presc) @(negedge FSM_CLK);
   endtask

   // Short low pulse on an idle line: rejected at the end of the start bit.
   task automatic glitch(input int presc, input int low_clks);
      longint k0;
      Prescale = PW'(presc);
      RX_IN    = 1'b0;
      k0       = cyc + 1;
      repeat (low_clks) @(negedge FSM_CLK);
      RX_IN = 1'b1;
      while (cyc < k0 + presc - 1) @(negedge FSM_CLK);
      #1 check("glitch_busy_mid", busy, 1'b1);
      @(negedge FSM_CLK);
      #1 check("glitch_busy_drop", busy, 1'b0);
      prev_end = k0 + presc;
      @(negedge FSM_CLK);
   endtask

   task automatic wait_drain();
      int budget;
      budget = 4000;
      while (exp_q.size() != 0 && budget > 0) begin
         @(negedge FSM_CLK);
         #1 budget--;
      end
      check("drain_pending", exp_q.size(), 0);
      exp_q.delete();
      @(negedge FSM_CLK);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      longint     k0;
      logic [3:0] dl;
      int         p;
      bit         pf;
      bit [1:0]   sl;

      FSM_RST  = 1'b0;
      RX_IN    = 1'b1;
      PAR_EN   = 1'b0;
      PAR_TYP  = 1'b0;
      STOP2    = 1'b0;
      DATA_LEN = 4'd8;
      Prescale = PW'(8);
      #3;
      check("rst_p_data", P_DATA, '0);
      check("rst_data_valid", data_valid, 1'b0);
      check("rst_par_err", par_err, 1'b0);
      check("rst_stp_err", stp_err, 1'b0);
      check("rst_busy", busy, 1'b0);
      repeat (2) @(negedge FSM_CLK);
      FSM_RST = 1'b1;
      mon_en  = 1'b1;
      repeat (2) @(negedge FSM_CLK);

      // 8N1 at 8 clocks/bit; latency counted to the first edge that captures data_valid.
      send_frame(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 8, 1'b0, 2'b00, 1, 0, k0);
      wait_drain();
      check("t1_latency", last_pulse_cyc - k0 + 1, 81);
      check("t1_p_data", P_DATA, 8'hA5);

      // 8E1, 0x3C has even weight so its parity bit is 0; sending 1 must flag.
      send_frame(8'h3C, 4'd8, 1'b1, 1'b0, 1'b0, 16, 1'b1, 2'b00, 1, 0, k0);
      wait_drain();
      check("t2_p_data_held", P_DATA, 8'hA5);

      // 7O2 with the second stop bit low, then a clean 7O2 frame.
      send_frame(8'h55, 4'd7, 1'b1, 1'b1, 1'b1, 8, 1'b0, 2'b10, 1, 0, k0);
      send_frame(8'h2A, 4'd7, 1'b1, 1'b1, 1'b1, 8, 1'b0, 2'b00, 1, 0, k0);
      wait_drain();
      check("t3_p_data", P_DATA, 8'h2A);

      glitch(16, 3);
      check("t4_p_data_held", P_DATA, 8'h2A);

      // Back-to-back 8N1 frames with no idle gap.
      send_frame(8'h01, 4'd8, 1'b0, 1'b0, 1'b0, 8, 1'b0, 2'b00, 0, 0, k0);
      send_frame(8'hFE, 4'd8, 1'b0, 1'b0, 1'b0, 8, 1'b0, 2'b00, 1, 0, k0);
      wait_drain();
      check("t5_p_data", P_DATA, 8'hFE);

      // Reset in the middle of the data bits.
      send_frame(8'h5A, 4'd8, 1'b0, 1'b0, 1'b0, 8, 1'b0, 2'b00, 0, 4, k0);
      check("t6_busy_before", busy, 1'b1);
      #2 FSM_RST = 1'b0;
      #1;
      check("t6_rst_p_data", P_DATA, '0);
      check("t6_rst_busy", busy, 1'b0);
      check("t6_rst_pulses", {data_valid, par_err, stp_err}, 3'b000);
      exp_q.delete();
      last_good = '0;
      prev_end  = 0;
      @(negedge FSM_CLK);
      FSM_RST = 1'b1;
      repeat (3) @(negedge FSM_CLK);
      send_frame(8'h81, 4'd8, 1'b0, 1'b0, 1'b0, 8, 1'b0, 2'b00, 1, 0, k0);
      wait_drain();
      check("t6_p_data", P_DATA, 8'h81);

      // Random configurations, errors and gaps, including out-of-range DATA_LEN.
      for (int f = 0; f < 40; f++) begin
         dl = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(5, 8));
         p  = $urandom_range(8, 20);
         pf = ($urandom_range(0, 4) == 0);
         sl = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         send_frame(8'($urandom), dl, 1'($urandom), 1'($urandom), 1'($urandom), p, pf, sl,
                    $urandom_range(0, 2), 0, k0);
      end
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
